// File: rtl/ex_operand_latch.sv
// ID/EX operand and control latch with load-use bubble insertion and a saturating bubble counter.
// Define EX_OPERAND_FORWARD_EN to bypass writeback data into the rs/rt operands at capture time.
module ex_operand_latch #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [5:0]        rs_addr,
  input  logic [5:0]        rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic [5:0]        rd_addr,
  input  logic              wb_we,
  input  logic [5:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_d1,
  output logic [DATA_W-1:0] ex_d2,
  output logic              ex_sel,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [5:0]        ex_rd_addr,
  output logic              hazard,
  output logic [15:0]       bubble_count
);

  localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == BUBBLE_MAX) ? v : v + 16'd1;
  endfunction

  function automatic logic signed [DATA_W-1:0] pick_operand(input logic              fwd,
                                                            input logic [DATA_W-1:0] wb,
                                                            input logic [DATA_W-1:0] rf);
    return fwd ? wb : rf;
  endfunction

  logic                     vld_p1_q, vld_p1_d;
  logic signed [DATA_W-1:0] a_p1_q, a_p1_d;
  logic signed [DATA_W-1:0] d1_p1_q, d1_p1_d;
  logic signed [DATA_W-1:0] d2_p1_q, d2_p1_d;
  logic                     sel_p1_q, sel_p1_d;
  logic                     rw_p1_q, rw_p1_d;
  logic                     mr_p1_q, mr_p1_d;
  logic [5:0]               rd_p1_q, rd_p1_d;
  logic [15:0]              bubble_q, bubble_d;
  logic                     fwd_rs, fwd_rt;
  logic                     hazard_w;

`ifdef EX_OPERAND_FORWARD_EN
  assign fwd_rs = wb_we && (wb_addr == rs_addr);
  assign fwd_rt = wb_we && (wb_addr == rt_addr);
`else
  logic unused_wb;
  assign fwd_rs    = 1'b0;
  assign fwd_rt    = 1'b0;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  // A load in EX whose destination feeds the instruction in decode cannot be bypassed in time.
  assign hazard_w = in_valid && vld_p1_q && mr_p1_q && rw_p1_q &&
                    ((rd_p1_q == rs_addr) || (rd_p1_q == rt_addr));

  always_comb begin
    vld_p1_d = vld_p1_q;
    a_p1_d   = a_p1_q;
    d1_p1_d  = d1_p1_q;
    d2_p1_d  = d2_p1_q;
    sel_p1_d = sel_p1_q;
    rw_p1_d  = rw_p1_q;
    mr_p1_d  = mr_p1_q;
    rd_p1_d  = rd_p1_q;
    bubble_d = bubble_q;
    if (flush) begin
      vld_p1_d = 1'b0;
      sel_p1_d = 1'b0;
      rw_p1_d  = 1'b0;
      mr_p1_d  = 1'b0;
    end else if (!stall) begin
      if (hazard_w) begin
        vld_p1_d = 1'b0;
        sel_p1_d = 1'b0;
        rw_p1_d  = 1'b0;
        mr_p1_d  = 1'b0;
        bubble_d = sat_inc(bubble_q);
      end else begin
        vld_p1_d = in_valid;
        a_p1_d   = pick_operand(fwd_rs, wb_data, rs_data);
        d1_p1_d  = pick_operand(fwd_rt, wb_data, rt_data);
        d2_p1_d  = imm;
        sel_p1_d = in_valid & alu_src;
        rw_p1_d  = in_valid & reg_write;
        mr_p1_d  = in_valid & mem_read;
        rd_p1_d  = rd_addr;
      end
    end
  end

  // Decode -> EX stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      a_p1_q   <= '0;
      d1_p1_q  <= '0;
      d2_p1_q  <= '0;
      sel_p1_q <= 1'b0;
      rw_p1_q  <= 1'b0;
      mr_p1_q  <= 1'b0;
      rd_p1_q  <= '0;
      bubble_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      a_p1_q   <= a_p1_d;
      d1_p1_q  <= d1_p1_d;
      d2_p1_q  <= d2_p1_d;
      sel_p1_q <= sel_p1_d;
      rw_p1_q  <= rw_p1_d;
      mr_p1_q  <= mr_p1_d;
      rd_p1_q  <= rd_p1_d;
      bubble_q <= bubble_d;
    end
  end

  assign ex_valid     = vld_p1_q;
  assign ex_a         = a_p1_q;
  assign ex_d1        = d1_p1_q;
  assign ex_d2        = d2_p1_q;
  assign ex_sel       = sel_p1_q;
  assign ex_reg_write = rw_p1_q;
  assign ex_mem_read  = mr_p1_q;
  assign ex_rd_addr   = rd_p1_q;
  assign hazard       = hazard_w;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_ex_operand_latch.sv
// Testbench for ex_operand_latch: directed vector table, randomized run against a behavioural
// model, and a long load-use sequence that drives the bubble counter into saturation.
module tb_ex_operand_latch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, stall, flush;
  logic [5:0]  rs_addr, rt_addr, rd_addr, wb_addr;
  logic [31:0] rs_data, rt_data, imm, wb_data;
  logic        alu_src, reg_write, mem_read, wb_we;
  logic        ex_valid, ex_sel, ex_reg_write, ex_mem_read, hazard;
  logic [31:0] ex_a, ex_d1, ex_d2;
  logic [5:0]  ex_rd_addr;
  logic [15:0] bubble_count;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef EX_OPERAND_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  ex_operand_latch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read), .rd_addr(rd_addr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_d1(ex_d1), .ex_d2(ex_d2), .ex_sel(ex_sel),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .hazard(hazard), .bubble_count(bubble_count)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] a, d1, d2;
    logic        sel, rw, mr;
    logic [5:0]  rd;
    logic [15:0] bc;
  } st_t;

  typedef struct packed {
    logic        r, iv, st, fl;
    logic [5:0]  rsa, rta;
    logic [31:0] rs, rt, im;
    logic        src, rw, mr;
    logic [5:0]  rd;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
  } in_t;

  typedef struct packed {
    in_t  i;
    logic hz;
    st_t  e;
  } vec_t;

  vec_t tbl[$];
  st_t  m;

  function automatic in_t I(logic r, logic iv, logic st, logic fl, logic [5:0] rsa, logic [5:0] rta,
                            logic [31:0] rs, logic [31:0] rt, logic [31:0] im, logic src,
                            logic rw, logic mr, logic [5:0] rd, logic we, logic [5:0] wa,
                            logic [31:0] wd);
    in_t x;
    x.r = r; x.iv = iv; x.st = st; x.fl = fl; x.rsa = rsa; x.rta = rta;
    x.rs = rs; x.rt = rt; x.im = im; x.src = src; x.rw = rw; x.mr = mr;
    x.rd = rd; x.we = we; x.wa = wa; x.wd = wd;
    return x;
  endfunction

  function automatic st_t E(logic v, logic [31:0] a, logic [31:0] d1, logic [31:0] d2, logic sel,
                            logic rw, logic mr, logic [5:0] rd, logic [15:0] bc);
    st_t s;
    s.v = v; s.a = a; s.d1 = d1; s.d2 = d2; s.sel = sel; s.rw = rw; s.mr = mr;
    s.rd = rd; s.bc = bc;
    return s;
  endfunction

  task automatic add(input in_t i, input logic hz, input st_t e);
    vec_t x;
    x.i = i; x.hz = hz; x.e = e;
    tbl.push_back(x);
  endtask

  task automatic drive(input in_t x);
    rst = x.r; in_valid = x.iv; stall = x.st; flush = x.fl;
    rs_addr = x.rsa; rt_addr = x.rta; rs_data = x.rs; rt_data = x.rt; imm = x.im;
    alu_src = x.src; reg_write = x.rw; mem_read = x.mr; rd_addr = x.rd;
    wb_we = x.we; wb_addr = x.wa; wb_data = x.wd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input st_t e, input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(e.v));
    chk({tag, ".ex_a"}, ex_a, e.a);
    chk({tag, ".ex_d1"}, ex_d1, e.d1);
    chk({tag, ".ex_d2"}, ex_d2, e.d2);
    chk({tag, ".ex_sel"}, 32'(ex_sel), 32'(e.sel));
    chk({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(e.rw));
    chk({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(e.mr));
    chk({tag, ".ex_rd_addr"}, 32'(ex_rd_addr), 32'(e.rd));
    chk({tag, ".bubble_count"}, 32'(bubble_count), 32'(e.bc));
  endtask

  // Reference behaviour: priority reset > flush > stall > load-use bubble > capture.
  function automatic logic model_hazard();
    return in_valid && m.v && m.mr && m.rw && ((m.rd == rs_addr) || (m.rd == rt_addr));
  endfunction

  task automatic model_step(input logic hz);
    if (rst) begin
      m = '0;
    end else if (flush) begin
      m.v = 1'b0; m.sel = 1'b0; m.rw = 1'b0; m.mr = 1'b0;
    end else if (stall) begin
      m = m;
    end else if (hz) begin
      m.v = 1'b0; m.sel = 1'b0; m.rw = 1'b0; m.mr = 1'b0;
      if (m.bc < 16'hFFFF) m.bc = m.bc + 16'd1;
    end else begin
      m.v  = in_valid;
      m.a  = (FWD && wb_we && wb_addr == rs_addr) ? wb_data : rs_data;
      m.d1 = (FWD && wb_we && wb_addr == rt_addr) ? wb_data : rt_data;
      m.d2 = imm;
      m.sel = in_valid && alu_src;
      m.rw  = in_valid && reg_write;
      m.mr  = in_valid && mem_read;
      m.rd  = rd_addr;
    end
  endtask

  task automatic tick(input bit chk_model);
    logic hz;
    #1;
    hz = model_hazard();
    if (chk_model) chk("hazard", 32'(hazard), 32'(hz));
    model_step(hz);
    @(posedge clk);
    #1;
    if (chk_model) check_outputs(m, "model");
    @(negedge clk);
  endtask

  initial begin
    in_t x;
    string tag;

    add(I(1,1,1,1, 6'h3f,6'h3f, '1,'1,'1, 1,1,1, 6'h3f, 1,6'h3f,'1), 1'bx,
        E(0, 0, 0, 0, 0,0,0, 0, 0));
    add(I(0,1,0,0, 1,2, 'h11,'h22,'hFFFFFFF0, 1,1,0, 5, 0,0,0), 1'b0,
        E(1, 'h11, 'h22, 'hFFFFFFF0, 1,1,0, 5, 0));
    add(I(0,1,0,0, 1,2, 'h33,'h44,'h8, 1,1,1, 7, 0,0,0), 1'b0,
        E(1, 'h33, 'h44, 'h8, 1,1,1, 7, 0));
    add(I(0,1,0,0, 7,0, 'h55,'h66,'h9, 0,1,0, 9, 0,0,0), 1'b1,
        E(0, 'h33, 'h44, 'h8, 0,0,0, 7, 1));
    add(I(0,1,0,0, 7,0, 'h55,'h66,'h9, 0,1,0, 9, 0,0,0), 1'b0,
        E(1, 'h55, 'h66, 'h9, 0,1,0, 9, 1));
    add(I(0,1,1,1, 1,2, 'h99,'h98,'h97, 1,1,1, 10, 0,0,0), 1'b0,
        E(0, 'h55, 'h66, 'h9, 0,0,0, 9, 1));
    add(I(0,1,0,0, 1,2, 'hA1,'hA2,'hA3, 1,1,1, 12, 0,0,0), 1'b0,
        E(1, 'hA1, 'hA2, 'hA3, 1,1,1, 12, 1));
    add(I(0,1,1,0, 12,2, 'hB1,'hB2,'hB3, 0,0,0, 13, 0,0,0), 1'b1,
        E(1, 'hA1, 'hA2, 'hA3, 1,1,1, 12, 1));
    add(I(0,1,1,0, 2,12, 'hC1,'hC2,'hC3, 0,1,0, 14, 1,2,'h5), 1'b1,
        E(1, 'hA1, 'hA2, 'hA3, 1,1,1, 12, 1));
    add(I(0,0,1,0, 12,12, 'hD1,'hD2,'hD3, 1,1,1, 15, 0,0,0), 1'b0,
        E(1, 'hA1, 'hA2, 'hA3, 1,1,1, 12, 1));
    add(I(0,1,0,0, 2,12, 'hB1,'hB2,'hB3, 0,1,0, 13, 0,0,0), 1'b1,
        E(0, 'hA1, 'hA2, 'hA3, 0,0,0, 12, 2));
    add(I(0,0,0,0, 12,12, 'h77,'h78,'h79, 1,1,1, 3, 0,0,0), 1'b0,
        E(0, 'h77, 'h78, 'h79, 0,0,0, 3, 2));
    add(I(0,1,0,0, 3,4, 'h0,'h5,'h6, 0,0,0, 1, 1,3,'hABCD), 1'b0,
        E(1, FWD ? 32'hABCD : 32'h0, 'h5, 'h6, 0,0,0, 1, 2));
    add(I(0,1,0,0, 3,4, 'h1,'h0,'h6, 0,0,0, 1, 1,4,'h1234), 1'b0,
        E(1, 'h1, FWD ? 32'h1234 : 32'h0, 'h6, 0,0,0, 1, 2));
    add(I(0,1,0,0, 3,4, 'h42,'h43,'h44, 1,0,1, 2, 0,3,'hDEAD), 1'b0,
        E(1, 'h42, 'h43, 'h44, 1,0,1, 2, 2));
    add(I(0,1,0,0, 1,1, 'hC1,'hC2,'hC3, 0,1,1, 8, 0,0,0), 1'b0,
        E(1, 'hC1, 'hC2, 'hC3, 0,1,1, 8, 2));
    add(I(1,1,1,0, 8,8, 'hD1,'hD2,'hD3, 1,1,1, 9, 0,0,0), 1'b1,
        E(0, 0, 0, 0, 0,0,0, 0, 0));
    add(I(0,1,0,0, 8,8, 'hE1,'hE2,'hE3, 1,1,0, 4, 0,0,0), 1'b0,
        E(1, 'hE1, 'hE2, 'hE3, 1,1,0, 4, 0));
    add(I(0,1,0,0, 0,0, 'hF1,'hF2,'hF3, 0,1,1, 11, 0,0,0), 1'b0,
        E(1, 'hF1, 'hF2, 'hF3, 0,1,1, 11, 0));
    add(I(0,1,0,1, 11,0, 'h01,'h02,'h03, 1,1,1, 5, 0,0,0), 1'b1,
        E(0, 'hF1, 'hF2, 'hF3, 0,0,0, 11, 0));

    foreach (tbl[i]) begin
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].i);
      #1;
      if (!$isunknown(tbl[i].hz)) chk({tag, ".hazard"}, 32'(hazard), 32'(tbl[i].hz));
      tick(1'b0);
      check_outputs(tbl[i].e, tag);
    end

    for (int k = 0; k < 3000; k++) begin
      x = I($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom,
            1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)),
            1'($urandom), 6'($urandom_range(0, 7)), $urandom);
      drive(x);
      tick(1'b1);
    end

    drive(I(1,0,0,0, 0,0, 0,0,0, 0,0,0, 0, 0,0,0));
    tick(1'b1);
    drive(I(0,1,0,0, 7,7, 'h1234,'h5678,'h9, 0,1,1, 7, 0,0,0));
    tick(1'b1);
    for (int k = 0; k < 65534; k++) begin
      tick(1'b0);
      tick(1'b0);
    end
    chk("sat.bubble_65534", 32'(bubble_count), 32'h0000FFFE);
    tick(1'b0);
    tick(1'b0);
    chk("sat.bubble_65535", 32'(bubble_count), 32'h0000FFFF);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0);
      tick(1'b0);
    end
    chk("sat.bubble_65540", 32'(bubble_count), 32'h0000FFFF);
    check_outputs(m, "sat");
    tick(1'b1);
    tick(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_latch.md
EX_OPERAND_LATCH -- requirements
Module: ex_operand_latch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, decode stage presents a valid instruction.
REQ-004 SHALL have port stall, input, 1, downstream hold request.
REQ-005 SHALL have port flush, input, 1, squash request from branch resolution.
REQ-006 SHALL have ports rs_addr and rt_addr, input, 6 each, source register numbers.
REQ-007 SHALL have ports rs_data and rt_data, input, 32 each, register-file read data.
REQ-008 SHALL have port imm, input, 32, sign-extended immediate.
REQ-009 SHALL have ports alu_src, reg_write, mem_read, input, 1 each, decoded controls.
REQ-010 SHALL have port rd_addr, input, 6, destination register number.
REQ-011 SHALL have ports wb_we (1), wb_addr (6), wb_data (32), input, writeback bypass source.
REQ-012 SHALL have port ex_valid, output, 1, latched instruction valid.
REQ-013 SHALL have ports ex_a, ex_d1, ex_d2, output, 32 each: rs operand, rt operand, immediate; ex_d1/ex_d2 drive the downstream 2:1 operand mux data inputs.
REQ-014 SHALL have ports ex_sel, ex_reg_write, ex_mem_read, output, 1 each; ex_sel drives that mux's select (0 -> ex_d1, 1 -> ex_d2).
REQ-015 SHALL have port ex_rd_addr, output, 6.
REQ-016 SHALL have port hazard, output, 1, combinational load-use stall request to upstream.
REQ-017 SHALL have port bubble_count, output, 16, saturating count of inserted bubbles.

Function
REQ-018 hazard SHALL equal in_valid & ex_valid & ex_mem_read & ex_reg_write & (ex_rd_addr==rs_addr | ex_rd_addr==rt_addr).
REQ-019 Per-edge priority SHALL be: rst > flush > stall > hazard > load.
REQ-020 flush: ex_valid<=0, all control outputs <=0, data outputs unchanged, regardless of stall.
REQ-021 stall (no flush): every output register holds value; hazard still evaluated combinationally.
REQ-022 hazard (no flush/stall): insert bubble -- ex_valid<=0, controls<=0, data unchanged, bubble_count+1 unless 16'hFFFF.
REQ-023 load: all inputs captured; ex_valid<=in_valid; in_valid=0 SHALL force controls to 0.
REQ-024 Latency SHALL be exactly one cycle from capture to output; no combinational input-to-output path except hazard.
REQ-025 ex_sel SHALL be only the latched alu_src; the block SHALL never mux operands itself.
REQ-026 Bubble after hazard SHALL last one cycle; next edge loads the held instruction normally.
REQ-027 bubble_count SHALL saturate at 16'hFFFF, never wrap.

Reset
REQ-028 On rst at clk edge: ex_valid, ex_a, ex_d1, ex_d2, ex_sel, ex_reg_write, ex_mem_read, ex_rd_addr SHALL be 0; bubble_count SHALL be 0.
REQ-029 Reset mid-stall or mid-hazard SHALL discard held instruction; first post-reset edge SHALL load normally.

Configuration
REQ-030 Macro EX_OPERAND_FORWARD_EN: when defined, on load, if wb_we & wb_addr==rs_addr, ex_a SHALL capture wb_data instead of rs_data (same for rt_addr/ex_d1), both independently.
REQ-031 Without EX_OPERAND_FORWARD_EN, wb_we/wb_addr/wb_data SHALL be ignored; ports remain.

Verification
REQ-032 rst=1 one edge with all inputs 1 -> every output 0, bubble_count 0.
REQ-033 Load rs_data=32'h11, rt_data=32'h22, imm=32'hFFFFFFF0, alu_src=1, rd_addr=5 -> next cycle ex_a=11, ex_d1=22, ex_d2=FFFFFFF0, ex_sel=1, ex_valid=1.
REQ-034 Latched load (mem_read=1, reg_write=1, rd_addr=7) then in_valid with rs_addr=7 -> hazard=1, next edge ex_valid=0, bubble_count=1, following edge instruction loaded.
REQ-035 stall=1 and flush=1 same edge with valid latched -> ex_valid=0; stall=1 alone for 3 cycles -> outputs unchanged.
REQ-036 Forward-enabled build: wb_we=1, wb_addr=rs_addr=3, wb_data=32'hABCD, rs_data=0 -> ex_a=32'hABCD; disabled build -> ex_a=0.
REQ-037 Force 65540 hazards -> bubble_count=16'hFFFF.
